// File: rtl/vedic_mul_arbiter_if.sv
// Request/response bundle between NREQ multiply clients and the shared vedic multiplier.
// Handshake: a request moves when req_valid[i] & req_ready[i]; a response moves when rsp_valid & rsp_ready.
interface vedic_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_p;
    logic [IDW-1:0]    rsp_id;
    logic [CNTW-1:0]   op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_id, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_id, op_count
    );
endinterface

// File: rtl/vedic_mul_arbiter.sv
// Round-robin sharing of one vedic 4x4 multiplier with a registered 1-entry response stage.
// Output-stage state is visible on rsp_valid (EMPTY=0, FULL=1).
module vedic4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic c;
        logic [3:0] r;
        c    = x[1] & y[0] & x[0] & y[1];
        r[0] = x[0] & y[0];
        r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        r[2] = (x[1] & y[1]) ^ c;
        r[3] = x[1] & y[1] & c;
        return r;
    endfunction

    logic [3:0] q0, q1, q2, q3;
    logic [7:0] mid;

    always_comb begin
        q0  = vedic2(a[1:0], b[1:0]);
        q1  = vedic2(a[3:2], b[1:0]);
        q2  = vedic2(a[1:0], b[3:2]);
        q3  = vedic2(a[3:2], b[3:2]);
        // Cross terms share weight 4, so they are summed before shifting.
        mid = {4'b0000, q1} + {4'b0000, q2};
        p   = {4'b0000, q0} + (mid << 2) + {q3, 4'b0000};
    end
endmodule

module vedic_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input logic clk,
    input logic rst,
    vedic_mul_arbiter_if.slave bus
);
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} out_state_e;

    out_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_p_q, rsp_p_d;
    logic [CNTW-1:0] op_count_q, op_count_d;

    logic            found, accept, grant;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] req_ready;
    logic [3:0]      a_sel, b_sel;
    logic [7:0]      product;

    // Cyclic search starting at ptr; the first valid bit wins.
    always_comb begin : arb
        logic [IDW:0] sum;
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            if (!found && bus.req_valid[sum[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        accept    = (state_q == ST_EMPTY) | bus.rsp_ready;
        grant     = found & accept & ~rst;
        req_ready = '0;
        if (grant) req_ready[grant_idx] = 1'b1;
        a_sel = bus.req_a[{grant_idx, 2'b00} +: 4];
        b_sel = bus.req_b[{grant_idx, 2'b00} +: 4];
    end

    vedic4bit u_mul (
        .a(a_sel),
        .b(b_sel),
        .p(product)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_p_d    = rsp_p_q;
        rsp_id_d   = rsp_id_q;
        op_count_d = op_count_q;
        if (grant) begin
            state_d    = ST_FULL;
            rsp_p_d    = product;
            rsp_id_d   = grant_idx;
            op_count_d = op_count_q + CNTW'(1);
            ptr_d      = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (bus.rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= '0;
            rsp_p_q    <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_p_q    <= rsp_p_d;
            rsp_id_q   <= rsp_id_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.op_count  = op_count_q;
endmodule
